// File: rtl/mem_target_pkg.sv
// Shared types and helpers for the mem_target request/response memory.
// Word geometry comes from `WIDTH / `ADDR_WIDTH; MEM_TARGET_PARITY_EN adds a parity bit per word.
`ifndef WIDTH
`define WIDTH 8
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif

package mem_target_pkg;

    localparam int unsigned DATA_W              = `WIDTH;
    localparam int unsigned ADDR_W              = `ADDR_WIDTH;
    localparam int unsigned DEPTH               = 1 << ADDR_W;
    localparam int unsigned CNT_W               = 4;
    localparam int unsigned WAIT_CYCLES_DEFAULT = 2;

`ifdef MEM_TARGET_PARITY_EN
    localparam int unsigned WORD_W = DATA_W + 1;
`else
    localparam int unsigned WORD_W = DATA_W;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Request payload captured at acceptance.
    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
`ifdef MEM_TARGET_PARITY_EN
        logic              inj;
`endif
    } req_t;

    // Bit that makes the total number of ones (data + parity) even.
    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/mem_target_array.sv
// Synchronous single-port word store; read data held until the next read.
// With MEM_TARGET_PARITY_EN each word carries a parity bit and reads flag a mismatch.
module mem_target_array
    import mem_target_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
`ifdef MEM_TARGET_PARITY_EN
    output logic              err,
`endif
    output logic [DATA_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Contents are deliberately never reset.
    always_ff @(posedge clk_i) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr][DATA_W-1:0];
        end
    end

`ifdef MEM_TARGET_PARITY_EN
    // Error is a single-cycle flag aligned with the read data update.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err <= 1'b0;
        end else begin
            err <= en && !we &&
                   (even_parity(mem[addr][DATA_W-1:0]) != mem[addr][DATA_W]);
        end
    end
`endif

endmodule

// File: rtl/mem_target.sv
// Single-outstanding memory target: accept, wait WAIT_CYCLES, then one-cycle ready pulse.
// Optional parity storage/checking enabled by defining MEM_TARGET_PARITY_EN.
module mem_target
    import mem_target_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic              wr_rd,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
`ifdef MEM_TARGET_PARITY_EN
    input  logic              parity_inj_i,
    output logic              err_o,
`endif
    output logic [DATA_W-1:0] rdata_o,
    output logic              ready_o
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    req_t              req_q, req_d;
    req_t              req_in_c;
    req_t              cur_c;
    logic              resp_c;
    logic              ready_d;
    logic              mem_en_c;
    logic              mem_we_c;
    logic [ADDR_W-1:0] mem_addr_c;
    logic [WORD_W-1:0] mem_wdata_c;

    always_comb begin
        req_in_c       = '0;
        req_in_c.wr    = wr_rd;
        req_in_c.addr  = addr_i;
        req_in_c.wdata = wdata_i;
`ifdef MEM_TARGET_PARITY_EN
        req_in_c.inj   = parity_inj_i;
`endif
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            ready_o <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            ready_o <= ready_d;
        end
    end

    // Next state; resp_c marks the edge that enters RESP
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        resp_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (valid_i) begin
                    req_d = req_in_c;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_RESP;
                        resp_c  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_RESP;
                    cnt_d   = '0;
                    resp_c  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: with zero wait the live request is used since nothing is latched yet
    always_comb begin
        mem_en_c    = 1'b0;
        mem_we_c    = 1'b0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        ready_d     = resp_c;
        cur_c       = (state_q == ST_IDLE) ? req_in_c : req_q;
        if (resp_c && !rst_i) begin
            mem_en_c   = 1'b1;
            mem_we_c   = cur_c.wr;
            mem_addr_c = cur_c.addr;
`ifdef MEM_TARGET_PARITY_EN
            mem_wdata_c = {even_parity(cur_c.wdata) ^ cur_c.inj, cur_c.wdata};
`else
            mem_wdata_c = cur_c.wdata;
`endif
        end
    end

    mem_target_array u_array (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (mem_en_c),
        .we    (mem_we_c),
        .addr  (mem_addr_c),
        .wdata (mem_wdata_c),
`ifdef MEM_TARGET_PARITY_EN
        .err   (err_o),
`endif
        .rdata (rdata_o)
    );

endmodule

// File: tb/tb_mem_target.sv
// Randomized scoreboard bench for mem_target at WAIT_CYCLES=2 and WAIT_CYCLES=0.
// Parity checks are included when MEM_TARGET_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_mem_target;
    import mem_target_pkg::*;

    localparam int unsigned DW = DATA_W;
    localparam int unsigned AW = ADDR_W;

    typedef struct {
        bit                rd;
        logic [DW-1:0]     data;
        bit                err;
        longint unsigned   cyc;
    } exp_t;

    logic            clk = 1'b0;
    longint unsigned cyc = 0;
    int              total = 0;
    int              bad = 0;
    int              ndone = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input int unsigned wc, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL wc%0d %s: got %0h expected %0h at cycle %0d", wc, name, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int unsigned WC = (g == 0) ? 2 : 0;

        logic          rst;
        logic          valid;
        logic          wr_rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        logic          ready;
`ifdef MEM_TARGET_PARITY_EN
        logic          inj;
        logic          err;
        bit            mdl_bad [int];
`endif
        exp_t          exp_q[$];
        logic [DW-1:0] mdl_mem [int];
        int            wr_list[$];
        logic [DW-1:0] last_rd;

        mem_target #(.WAIT_CYCLES(WC)) u_dut (
            .clk_i        (clk),
            .rst_i        (rst),
            .valid_i      (valid),
            .wr_rd        (wr_rd),
            .addr_i       (addr),
            .wdata_i      (wdata),
`ifdef MEM_TARGET_PARITY_EN
            .parity_inj_i (inj),
            .err_o        (err),
`endif
            .rdata_o      (rdata),
            .ready_o      (ready)
        );

        // Monitor: compares every response and the hold/idle behaviour between them
        initial begin
            exp_t e;
            last_rd = '0;
            forever begin
                @(posedge clk);
                #1;
                if (rst) begin
                    last_rd = '0;
                    chk(WC, "rst_ready", 64'(ready), 64'(0));
                    chk(WC, "rst_rdata", 64'(rdata), 64'(0));
`ifdef MEM_TARGET_PARITY_EN
                    chk(WC, "rst_err", 64'(err), 64'(0));
`endif
                end else if (ready) begin
                    if (exp_q.size() == 0) begin
                        chk(WC, "spurious_ready", 64'(ready), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk(WC, "resp_cycle", 64'(cyc), 64'(e.cyc));
                        if (e.rd) begin
                            chk(WC, "rdata", 64'(rdata), 64'(e.data));
                            last_rd = e.data;
`ifdef MEM_TARGET_PARITY_EN
                            chk(WC, "err_rd", 64'(err), 64'(e.err));
`endif
                        end else begin
                            chk(WC, "rdata_after_wr", 64'(rdata), 64'(last_rd));
`ifdef MEM_TARGET_PARITY_EN
                            chk(WC, "err_wr", 64'(err), 64'(0));
`endif
                        end
                    end
                end else begin
                    chk(WC, "rdata_hold", 64'(rdata), 64'(last_rd));
`ifdef MEM_TARGET_PARITY_EN
                    chk(WC, "err_idle", 64'(err), 64'(0));
`endif
                    if (exp_q.size() != 0 && cyc > exp_q[0].cyc) begin
                        chk(WC, "resp_timeout", 64'(cyc), 64'(exp_q[0].cyc));
                        void'(exp_q.pop_front());
                    end
                end
            end
        end

        task automatic garbage();
            addr  = AW'($urandom);
            wdata = DW'($urandom);
            wr_rd = 1'($urandom);
`ifdef MEM_TARGET_PARITY_EN
            inj   = 1'($urandom);
`endif
        endtask

        // Called at a negedge with the DUT idle; the next posedge accepts
        task automatic issue(input bit rd, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input bit pinj);
            exp_t e;
            valid = 1'b1;
            wr_rd = !rd;
            addr  = a;
            wdata = d;
`ifdef MEM_TARGET_PARITY_EN
            inj   = pinj;
`endif
            e.rd   = rd;
            e.cyc  = cyc + 1 + WC;
            e.data = '0;
            e.err  = 1'b0;
            if (rd) begin
                e.data = mdl_mem[int'(a)];
`ifdef MEM_TARGET_PARITY_EN
                e.err = mdl_bad[int'(a)];
`endif
            end else begin
                mdl_mem[int'(a)] = d;
                wr_list.push_back(int'(a));
`ifdef MEM_TARGET_PARITY_EN
                mdl_bad[int'(a)] = pinj;
`endif
            end
            exp_q.push_back(e);
            @(negedge clk);
            // Busy edges, including the RESP exit edge: random valid must be ignored
            repeat (WC + 1) begin
                valid = 1'($urandom);
                garbage();
                @(negedge clk);
            end
            valid = 1'b0;
        endtask

        // Write that is killed by reset 'off' edges after acceptance
        task automatic abort_wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                input int unsigned off);
            valid = 1'b1;
            wr_rd = 1'b1;
            addr  = a;
            wdata = d;
`ifdef MEM_TARGET_PARITY_EN
            inj   = 1'b0;
`endif
            if (off == 0) rst = 1'b1;
            @(negedge clk);
            valid = 1'b0;
            garbage();
            if (off != 0) begin
                repeat (off - 1) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
            end
            rst = 1'b0;
            repeat (2) @(negedge clk);
        endtask

        // Driver
        initial begin
            bit            rd;
            logic [AW-1:0] a;
            rst   = 1'b1;
            valid = 1'b0;
            garbage();
            repeat (3) @(negedge clk);
            rst = 1'b0;
            @(negedge clk);

            issue(1'b0, AW'(8'h05), DW'(8'hA5), 1'b0);
            issue(1'b1, AW'(8'h05), '0, 1'b0);
            issue(1'b0, AW'(8'h00), DW'(8'h5A), 1'b0);
            issue(1'b1, AW'(8'h00), '0, 1'b0);
            issue(1'b0, AW'(8'h01), DW'(8'h11), 1'b0);
            abort_wr(AW'(8'h01), DW'(8'h3C), (WC > 0) ? 1 : 0);
            issue(1'b1, AW'(8'h01), '0, 1'b0);
            abort_wr(AW'(8'h01), DW'(8'h3C), WC);
            issue(1'b1, AW'(8'h01), '0, 1'b0);
            issue(1'b1, AW'(8'h05), '0, 1'b0);

            issue(1'b0, AW'(8'h02), DW'(8'hFF), 1'b1);
            issue(1'b1, AW'(8'h02), '0, 1'b0);
            issue(1'b0, AW'(8'h02), DW'(8'hFF), 1'b0);
            issue(1'b1, AW'(8'h02), '0, 1'b0);

            for (int i = 0; i < 300; i++) begin
                rd = (wr_list.size() != 0) && ($urandom_range(0, 1) == 1);
                if (rd) a = AW'(wr_list[$urandom_range(0, wr_list.size() - 1)]);
                else    a = AW'($urandom);
                issue(rd, a, DW'($urandom), 1'($urandom));
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end

            repeat (WC + 4) @(negedge clk);
            chk(WC, "queue_drained", 64'(exp_q.size()), 64'(0));
            ndone++;
        end
    end

    initial begin
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk);
            if (ndone == 2) break;
        end
        if (ndone != 2) chk(0, "watchdog_done", 64'(ndone), 64'(2));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_target.md
MEM_TARGET -- requirements
Module: mem_target

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, meaning number of wait cycles inserted between request acceptance and response; legal range 0..15.
REQ-002 Data width and address width SHALL come from global macros `WIDTH and `ADDR_WIDTH; depth = 2**`ADDR_WIDTH words.
REQ-003 clk_i  input  1  single clock; all logic on posedge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 valid_i  input  1  request valid from requester.
REQ-006 wr_rd  input  1  1 = write, 0 = read.
REQ-007 addr_i  input  `ADDR_WIDTH  word address.
REQ-008 wdata_i  input  `WIDTH  write data.
REQ-009 rdata_o  output  `WIDTH  read data, valid while ready_o=1 for a read.
REQ-010 ready_o  output  1  one-cycle completion pulse.

Function
REQ-011 FSM states IDLE, WAIT, RESP; all outputs registered.
REQ-012 IDLE: valid_i=1 at edge k -> latch addr_i/wdata_i/wr_rd; go WAIT with counter=WAIT_CYCLES, or RESP directly if WAIT_CYCLES=0.
REQ-013 WAIT: counter decrements each edge; on edge where counter=1 -> RESP.
REQ-014 Entering RESP: ready_o=1; read -> rdata_o loaded with mem[latched addr]; write -> mem[latched addr] written with latched wdata at that same edge.
REQ-015 First ready_o=1 cycle is cycle k+1+WAIT_CYCLES after accepting edge k; ready_o high exactly one cycle.
REQ-016 RESP -> IDLE unconditionally; valid_i sampled at the RESP-exit edge is ignored; next request accepted no earlier than the following edge.
REQ-017 Input changes (incl. valid_i dropping) after acceptance SHALL NOT affect the in-flight transaction.
REQ-018 rdata_o holds its last read value outside read responses; writes leave rdata_o unchanged.
REQ-019 Write then read of same address: read returns the written value (write commits before any later acceptance).
REQ-020 Full address space valid; no out-of-range condition; no wrap logic needed.

Reset
REQ-021 rst_i=1 at an edge -> state IDLE, ready_o=0, rdata_o=0, counter=0 (and err_o=0 when present).
REQ-022 Reset in WAIT aborts the transaction; no write commits; reset coincident with RESP entry edge wins (no commit, no ready_o).
REQ-023 Memory contents SHALL NOT be reset; unwritten words read as X.

Configuration
REQ-024 Macro MEM_TARGET_PARITY_EN defined: each word stores an extra even-parity bit computed on write; input parity_inj_i (1 bit) flips the stored parity bit on that write; output err_o (1 bit) asserted with ready_o on a read whose recomputed parity mismatches, else 0.
REQ-025 MEM_TARGET_PARITY_EN undefined: no parity storage, ports parity_inj_i and err_o absent; behaviour otherwise identical.

Structure
REQ-026 Package mem_target_pkg SHALL hold the FSM state enum typedef, WAIT_CYCLES default constant and the even-parity function.
REQ-027 Storage SHALL be a sub-module mem_target_array: synchronous single-port array, width `WIDTH (+1 with parity).

Verification
REQ-028 WAIT_CYCLES=2: write addr 0x05 data 0xA5 accepted edge k -> ready_o=1 only in cycle k+3; then read 0x05 -> rdata_o=0xA5 with ready_o.
REQ-029 WAIT_CYCLES=0: read accepted edge k -> ready_o=1 in cycle k+1; back-to-back requests complete every 2 cycles minimum.
REQ-030 valid_i dropped and addr_i changed one cycle after acceptance -> original transaction completes unchanged.
REQ-031 rst_i asserted during WAIT of write 0x3C to addr 0x01 -> ready_o stays 0; later read of 0x01 returns prior value, not 0x3C.
REQ-032 Parity build: write 0xFF with parity_inj_i=1 then read -> err_o=1 with ready_o; write 0xFF with parity_inj_i=0 then read -> err_o=0.
REQ-033 Read of never-read-before address 0x00 after reset: rdata_o=0 prior to the response, X-free after a preceding write.
